// File: rtl/sram_controller.sv
// sram_controller
//   Memory-stage responder between the pipeline and a 16-bit external SRAM.
//   A 32-bit load/store is split into two half-word accesses (low half first,
//   then high half). Each half is held for WAIT_CYC+1 cycles. `ready` stays low
//   for the whole access so that the pipeline freezes.
//
// Ports
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   rd_en, wr_en      : load / store request (store wins if both are high)
//   address           : byte address (ALU result)
//   write_data        : store data
//   read_data         : assembled load result, held between loads
//   ready             : 0 freezes the pipeline
//   sram_addr         : SRAM half-word address
//   sram_dq_out       : SRAM write data
//   sram_dq_oe        : 1 drives sram_dq_out onto the bus
//   sram_dq_in        : SRAM read data
//   sram_we_n         : SRAM write strobe, active-low
module sram_controller #(
    parameter int unsigned BASE_ADDR = 1024,
    parameter int unsigned SRAM_AW   = 18,
    parameter int unsigned WAIT_CYC  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    localparam int unsigned WI_W = SRAM_AW - 1;
    localparam logic [3:0]  LAST = 4'(WAIT_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [WI_W-1:0]   wi_q;
    logic [31:0]       wdata_q;
    logic              wr_q;
    logic [31:0]       rdata_q;

    logic              req;
    logic [WI_W-1:0]   wi_d;

    assign req  = rd_en | wr_en;
    // Word index: offset from BASE_ADDR (mod 2^32), dropping the byte bits;
    // anything beyond the SRAM range wraps by truncation.
    assign wi_d = WI_W'((address - BASE_ADDR) >> 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wi_q    <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        wi_q    <= wi_d;
                        wdata_q <= write_data;
                        wr_q    <= wr_en;
                        cnt_q   <= '0;
                        state_q <= S_LO;
                    end
                end
                S_LO: begin
                    if (cnt_q == LAST) begin
                        if (!wr_q) begin
                            rdata_q[15:0] <= sram_dq_in;
                        end
                        cnt_q   <= '0;
                        state_q <= S_HI;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_HI: begin
                    if (cnt_q == LAST) begin
                        if (!wr_q) begin
                            rdata_q[31:16] <= sram_dq_in;
                        end
                        cnt_q   <= '0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                // Any request seen here belongs to the instruction that is
                // completing, so it is deliberately ignored.
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // SRAM pins decode directly from state so a reset removes the write
    // strobe immediately, without waiting for a clock edge.
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state_q)
            S_LO: begin
                sram_addr = {wi_q, 1'b0};
                if (wr_q) begin
                    sram_dq_out = wdata_q[15:0];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end
            end
            S_HI: begin
                sram_addr = {wi_q, 1'b1};
                if (wr_q) begin
                    sram_dq_out = wdata_q[31:16];
                    sram_dq_oe  = 1'b1;
                    sram_we_n   = 1'b0;
                end
            end
            default: begin
                sram_addr   = '0;
                sram_dq_out = '0;
                sram_dq_oe  = 1'b0;
                sram_we_n   = 1'b1;
            end
        endcase
    end

    // Freeze asserts combinationally in the same cycle a request appears.
    assign ready     = ((state_q == S_IDLE) && !req) || (state_q == S_DONE);
    assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

    localparam int unsigned W    = 1;
    localparam int unsigned BASE = 1024;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Word-level reference memory and expected load register
    bit   [31:0] ref_mem [int unsigned];
    logic [31:0] exp_rd = 32'h0;

    // Half-word SRAM device attached to the DUT pins
    bit   [15:0] sram_mem [0:(1<<18)-1];

    sram_controller #(
        .BASE_ADDR (BASE),
        .SRAM_AW   (18),
        .WAIT_CYC  (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign sram_dq_in = sram_mem[sram_addr];
    always @(posedge clk) begin
        if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;
    end

    function automatic int unsigned word_of(input logic [31:0] a);
        return ((a - BASE) >> 2) & 32'h1FFFF;
    endfunction

    // One complete access starting in an IDLE cycle. mode: 0 = drop request
    // after cycle 0, 1 = random junk on inputs afterwards, 2 = hold request.
    task automatic run_access(input string tag, input bit rd, input bit wr,
                              input logic [31:0] a, input logic [31:0] d,
                              input int mode);
        int unsigned wi;
        int unsigned half;
        bit          isw;
        logic [31:0] word;
        logic [17:0] ea;
        logic [15:0] ed;
        isw  = wr;
        wi   = word_of(a);
        word = ref_mem.exists(wi) ? ref_mem[wi] : 32'h0;
        rd_en = rd; wr_en = wr; address = a; write_data = d;
        @(negedge clk);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_c0: got %b expected 0", tag, ready);
        end
        for (int k = 1; k <= int'(2*W+2); k++) begin
            @(posedge clk); #1;
            if (mode == 1) begin
                rd_en = 1'($urandom); wr_en = 1'($urandom);
                address = $urandom; write_data = $urandom;
            end else if (mode == 0) begin
                rd_en = 1'b0; wr_en = 1'b0;
            end
            @(negedge clk);
            half = (k - 1) / (W + 1);
            ea   = 18'(wi * 2 + half);
            ed   = isw ? ((half != 0) ? d[31:16] : d[15:0]) : 16'h0;
            checks++;
            if (ready !== 1'b0) begin
                errors++;
                $display("FAIL %s ready_c%0d: got %b expected 0", tag, k, ready);
            end
            checks++;
            if (sram_addr !== ea) begin
                errors++;
                $display("FAIL %s addr_c%0d: got %h expected %h", tag, k, sram_addr, ea);
            end
            checks++;
            if (sram_we_n !== !isw || sram_dq_oe !== isw) begin
                errors++;
                $display("FAIL %s strobe_c%0d: got we_n=%b oe=%b expected we_n=%b oe=%b",
                         tag, k, sram_we_n, sram_dq_oe, !isw, isw);
            end
            checks++;
            if (sram_dq_out !== ed) begin
                errors++;
                $display("FAIL %s dq_c%0d: got %h expected %h", tag, k, sram_dq_out, ed);
            end
        end
        if (isw) ref_mem[wi] = d;
        else     exp_rd = word;
        @(posedge clk); #1;
        if (mode == 1) begin
            rd_en = 1'($urandom); wr_en = 1'($urandom); address = $urandom;
        end else if (mode == 0) begin
            rd_en = 1'b0; wr_en = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1) begin
            errors++;
            $display("FAIL %s done: got ready=%b we_n=%b expected 1 1", tag, ready, sram_we_n);
        end
        checks++;
        if (read_data !== exp_rd) begin
            errors++;
            $display("FAIL %s read_data: got %h expected %h", tag, read_data, exp_rd);
        end
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; wr_en = 1'b1; rd_en = 1'b0; address = '0; write_data = '0;
        @(negedge clk);
        checks++;
        if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_addr !== 18'h0) begin
            errors++;
            $display("FAIL reset_pins: got we_n=%b oe=%b addr=%h expected 1 0 0",
                     sram_we_n, sram_dq_oe, sram_addr);
        end
        checks++;
        if (read_data !== 32'h0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_req: got read_data=%h ready=%b expected 0 0", read_data, ready);
        end
        wr_en = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_noreq: got ready=%b expected 1", ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_store;
        run_access("store", 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 0);
    endtask

    task automatic test_load;
        run_access("load", 1'b1, 1'b0, 32'd1032, 32'h0, 0);
        run_access("store_keeps_rd", 1'b0, 1'b1, 32'd1036, 32'h12345678, 0);
    endtask

    task automatic test_simultaneous;
        run_access("both", 1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, 0);
        run_access("both_readback", 1'b1, 1'b0, 32'd1040, 32'h0, 0);
    endtask

    task automatic test_reset_mid;
        logic [31:0] word;
        // store aborted while in the high half
        rd_en = 1'b0; wr_en = 1'b1; address = 32'd1100; write_data = 32'hA5A55A5A;
        @(posedge clk); #1; wr_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (sram_we_n !== 1'b0) begin
            errors++;
            $display("FAIL abort_pre: got we_n=%b expected 0", sram_we_n);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_addr !== 18'h0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_store: got we_n=%b oe=%b addr=%h ready=%b expected 1 0 0 1",
                     sram_we_n, sram_dq_oe, sram_addr, ready);
        end
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("FAIL abort_rd_clear: got %h expected 0", read_data);
        end
        // only the low half reached the SRAM before the abort
        word = ref_mem.exists(word_of(32'd1100)) ? ref_mem[word_of(32'd1100)] : 32'h0;
        ref_mem[word_of(32'd1100)] = {word[31:16], 16'h5A5A};
        exp_rd = 32'h0;
        @(posedge clk); #1; rst = 1'b0;
        // load aborted after its low half was captured
        word = ref_mem[word_of(32'd1032)];
        rd_en = 1'b1; address = 32'd1032;
        @(posedge clk); #1; rd_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (read_data !== {16'h0, word[15:0]}) begin
            errors++;
            $display("FAIL abort_partial: got %h expected %h", read_data, {16'h0, word[15:0]});
        end
        rst = 1'b1;
        #1;
        checks++;
        if (read_data !== 32'h0) begin
            errors++;
            $display("FAIL abort_load: got %h expected 0", read_data);
        end
        @(posedge clk); #1; rst = 1'b0;
        run_access("post_abort_load", 1'b1, 1'b0, 32'd1032, 32'h0, 0);
    endtask

    task automatic test_back_to_back;
        run_access("b2b_store", 1'b0, 1'b1, 32'd1020, 32'h0BADF00D, 2);
        run_access("b2b_wrap_load", 1'b1, 1'b0, 32'd1020, 32'h0, 0);
    endtask

    task automatic test_random;
        int unsigned op;
        logic [31:0] a;
        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 3);
            if ($urandom_range(0, 5) == 0) a = $urandom;
            else a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
            if (op == 0) begin
                rd_en = 1'b0; wr_en = 1'b0; address = $urandom;
                @(negedge clk);
                checks++;
                if (ready !== 1'b1 || sram_we_n !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_idle: got ready=%b we_n=%b expected 1 1", ready, sram_we_n);
                end
                @(posedge clk); #1;
            end else begin
                run_access("rand", op != 2, op >= 2, a, $urandom, 1);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store();
        test_load();
        test_simultaneous();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
